// File: rtl/uart_msg_pkg.sv
// Shared constants, types and header codes for the UART message path.
package uart_msg_pkg;

    localparam int DATA_WIDTH    = 8;
    localparam int MSG_WIDTH     = 64;
    localparam int HEADER_WIDTH  = 8;
    localparam int WORDS_PER_MSG = MSG_WIDTH / DATA_WIDTH;

    typedef logic [HEADER_WIDTH-1:0]           uart_header_t;
    typedef logic [MSG_WIDTH-HEADER_WIDTH-1:0] uart_payload_t;

    // Header codes decoded by the downstream dispatcher; the assembler ignores them.
    typedef enum logic [HEADER_WIDTH-1:0] {
        SYS_STATUS   = 8'h01,
        MEM_PARAMS   = 8'h02,
        MOD_PARAMS   = 8'h03,
        DEMOD_PARAMS = 8'h04,
        REPLACE_NUM  = 8'h05
    } uart_msg_type_e;

    // Assembler FSM states.
    typedef enum logic {
        ST_IDLE,
        ST_COLLECT
    } asm_state_e;

endpackage

// File: rtl/uart_msg_assembler_out_buffer.sv
// Single-entry valid/ready output register with overflow detection.
// A completing message replaces the entry when it is empty or draining this
// cycle; otherwise the new message is dropped and overflow_err pulses.
module msg_out_buffer #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             n_reset,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    input  logic             msg_ready,
    output logic             msg_valid,
    output logic [WIDTH-1:0] msg_data,
    output logic             overflow_err
);

    logic             valid_reg;
    logic [WIDTH-1:0] data_reg;
    logic             overflow_reg;

    // Buffer update: drop on full-and-stalled, load otherwise, clear on transfer.
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            valid_reg    <= 1'b0;
            data_reg     <= '0;
            overflow_reg <= 1'b0;
        end else begin
            overflow_reg <= 1'b0;
            if (load_valid && valid_reg && !msg_ready) begin
                overflow_reg <= 1'b1;
            end else if (load_valid) begin
                data_reg  <= load_data;
                valid_reg <= 1'b1;
            end else if (valid_reg && msg_ready) begin
                valid_reg <= 1'b0;
            end
        end
    end

    assign msg_valid    = valid_reg;
    assign msg_data     = data_reg;
    assign overflow_err = overflow_reg;

endmodule

// File: rtl/uart_msg_assembler.sv
// Collects LSB-first UART words into one message, discards partial messages
// after an inter-byte timeout, and hands complete messages to a one-entry buffer.
module uart_msg_assembler #(
    parameter int DATA_WIDTH   = uart_msg_pkg::DATA_WIDTH,
    parameter int MSG_WIDTH    = uart_msg_pkg::MSG_WIDTH,
    parameter int HEADER_WIDTH = uart_msg_pkg::HEADER_WIDTH,
    parameter int TIMEOUT_CLKS = 112500
) (
    input  logic                              clk,
    input  logic                              n_reset,
    input  logic [DATA_WIDTH-1:0]             byte_in,
    input  logic                              byte_valid,
    output logic [HEADER_WIDTH-1:0]           msg_header,
    output logic [MSG_WIDTH-HEADER_WIDTH-1:0] msg_payload,
    output logic                              msg_valid,
    input  logic                              msg_ready,
    output logic                              timeout_err,
    output logic                              overflow_err
);

    import uart_msg_pkg::*;

    localparam int WORDS   = MSG_WIDTH / DATA_WIDTH;
    localparam int CNT_W   = $clog2(WORDS + 1);
    localparam int TIMER_W = $clog2(TIMEOUT_CLKS + 1);

    localparam logic [CNT_W-1:0]   LAST_IDX    = CNT_W'(WORDS - 1);
    localparam logic [TIMER_W-1:0] TIMER_LIMIT = TIMER_W'(TIMEOUT_CLKS - 1);
    localparam logic [TIMER_W-1:0] TIMER_MAX   = TIMER_W'(TIMEOUT_CLKS);

    asm_state_e           state_reg, state_next;
    logic [CNT_W-1:0]     count_reg, count_next;
    logic [TIMER_W-1:0]   timer_reg, timer_next;
    logic                 timeout_reg, timeout_next;
    logic                 msg_complete;
    logic [MSG_WIDTH-1:0] shift_reg;
    logic [MSG_WIDTH-1:0] assembled;
    logic [MSG_WIDTH-1:0] buf_data;

    // The incoming word is merged into its slot combinationally so the final
    // byte can go straight to the output buffer on the edge that samples it.
    generate
        for (genvar gi = 0; gi < WORDS; gi++) begin : g_word
            assign assembled[gi*DATA_WIDTH +: DATA_WIDTH] =
                (byte_valid && count_reg == CNT_W'(gi)) ? byte_in
                                                        : shift_reg[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    // Capture every strobed word into the message register.
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            shift_reg <= '0;
        end else if (byte_valid) begin
            shift_reg <= assembled;
        end
    end

    // FSM, byte counter, idle timer and timeout pulse registers.
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            state_reg   <= ST_IDLE;
            count_reg   <= '0;
            timer_reg   <= '0;
            timeout_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            count_reg   <= count_next;
            timer_reg   <= timer_next;
            timeout_reg <= timeout_next;
        end
    end

    // Next-state logic; a byte always wins over a timeout in the same cycle.
    always_comb begin
        state_next   = state_reg;
        count_next   = count_reg;
        timer_next   = timer_reg;
        timeout_next = 1'b0;
        msg_complete = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                timer_next = '0;
                if (byte_valid) begin
                    if (count_reg == LAST_IDX) begin
                        msg_complete = 1'b1;
                        count_next   = '0;
                    end else begin
                        count_next = count_reg + CNT_W'(1);
                        state_next = ST_COLLECT;
                    end
                end
            end
            ST_COLLECT: begin
                if (byte_valid) begin
                    timer_next = '0;
                    if (count_reg == LAST_IDX) begin
                        msg_complete = 1'b1;
                        count_next   = '0;
                        state_next   = ST_IDLE;
                    end else begin
                        count_next = count_reg + CNT_W'(1);
                    end
                end else if (timer_reg == TIMER_LIMIT) begin
                    timeout_next = 1'b1;
                    count_next   = '0;
                    timer_next   = '0;
                    state_next   = ST_IDLE;
                end else if (timer_reg != TIMER_MAX) begin
                    timer_next = timer_reg + TIMER_W'(1);
                end
            end
            default: begin
                state_next = ST_IDLE;
                count_next = '0;
                timer_next = '0;
            end
        endcase
    end

    msg_out_buffer #(
        .WIDTH (MSG_WIDTH)
    ) u_out_buffer (
        .clk          (clk),
        .n_reset      (n_reset),
        .load_valid   (msg_complete),
        .load_data    (assembled),
        .msg_ready    (msg_ready),
        .msg_valid    (msg_valid),
        .msg_data     (buf_data),
        .overflow_err (overflow_err)
    );

    assign msg_header  = buf_data[HEADER_WIDTH-1:0];
    assign msg_payload = buf_data[MSG_WIDTH-1:HEADER_WIDTH];
    assign timeout_err = timeout_reg;

endmodule

// File: tb/tb_uart_msg_assembler.sv
// Scoreboard bench for uart_msg_assembler: stimulus pushes expected messages,
// a negedge monitor pops and compares on every valid/ready transfer.
module tb_uart_msg_assembler;

    localparam int TO = 20;

    logic        clk = 1'b0;
    logic        n_reset;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic [7:0]  msg_header;
    logic [55:0] msg_payload;
    logic        msg_valid;
    logic        msg_ready;
    logic        timeout_err;
    logic        overflow_err;

    int checks = 0;
    int errors = 0;
    int timeout_cnt = 0;
    int overflow_cnt = 0;
    int valid_cycles = 0;
    int t0, o0, v0;
    logic [63:0] exp_q[$];
    logic [63:0] exp_msg;
    logic [63:0] msg_d;

    always #5 clk = ~clk;

    uart_msg_assembler #(
        .DATA_WIDTH   (8),
        .MSG_WIDTH    (64),
        .HEADER_WIDTH (8),
        .TIMEOUT_CLKS (TO)
    ) dut (
        .clk          (clk),
        .n_reset      (n_reset),
        .byte_in      (byte_in),
        .byte_valid   (byte_valid),
        .msg_header   (msg_header),
        .msg_payload  (msg_payload),
        .msg_valid    (msg_valid),
        .msg_ready    (msg_ready),
        .timeout_err  (timeout_err),
        .overflow_err (overflow_err)
    );

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endfunction

    // Monitor: count pulses and compare every transfer against the scoreboard.
    always @(negedge clk) begin
        if (n_reset === 1'b1) begin
            if (timeout_err)  timeout_cnt++;
            if (overflow_err) overflow_cnt++;
            if (msg_valid)    valid_cycles++;
            if (msg_valid && msg_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_msg: got %h, expected no message", {msg_payload, msg_header});
                end else begin
                    exp_msg = exp_q.pop_front();
                    $display("xfer hdr=%h payload=%h (expected %h)", msg_header, msg_payload, exp_msg);
                    check("msg_header", 64'(msg_header), 64'(exp_msg[7:0]));
                    check("msg_payload", 64'(msg_payload), 64'(exp_msg[63:8]));
                end
            end
        end
    end

    task automatic drive_byte(input logic [7:0] b);
        @(posedge clk);
        #1;
        byte_in    = b;
        byte_valid = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            byte_valid = 1'b0;
        end
    endtask

    // Sends bytes LSB-first with 'gap' idle cycles between strobes; returns
    // just after the edge that samples the last byte.
    task automatic send_msg(input logic [63:0] m, input int gap);
        for (int i = 0; i < 8; i++) begin
            drive_byte(m[i*8 +: 8]);
            if (i < 7 && gap > 0) idle(gap);
        end
        idle(1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, expected bench to finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_reset    = 1'b0;
        byte_in    = 8'h00;
        byte_valid = 1'b0;
        msg_ready  = 1'b0;
        idle(3);
        check("rst_msg_valid", 64'(msg_valid), 64'd0);
        check("rst_header", 64'(msg_header), 64'd0);
        check("rst_payload", 64'(msg_payload), 64'd0);
        check("rst_timeout", 64'(timeout_err), 64'd0);
        check("rst_overflow", 64'(overflow_err), 64'd0);
        n_reset   = 1'b1;
        msg_ready = 1'b1;
        idle(2);

        // Basic message, spaced bytes, consumer ready.
        v0 = valid_cycles;
        exp_q.push_back(64'hEFCD_AB89_6745_2301);
        send_msg(64'hEFCD_AB89_6745_2301, 5);
        check("t1_latency_valid", 64'(msg_valid), 64'd1);
        idle(3);
        check("t1_valid_cycles", 64'(valid_cycles - v0), 64'd1);
        check("t1_drained", 64'(exp_q.size()), 64'd0);

        // Truncated message, exact timeout cycle, then realignment.
        t0 = timeout_cnt;
        v0 = valid_cycles;
        drive_byte(8'h31); idle(2);
        drive_byte(8'h32); idle(2);
        drive_byte(8'h33);
        idle(TO);
        check("t2_no_early_timeout", 64'(timeout_err), 64'd0);
        idle(1);
        check("t2_timeout_pulse", 64'(timeout_err), 64'd1);
        idle(1);
        check("t2_timeout_one_cycle", 64'(timeout_err), 64'd0);
        idle(3);
        check("t2_timeout_count", 64'(timeout_cnt - t0), 64'd1);
        check("t2_no_msg", 64'(valid_cycles - v0), 64'd0);
        exp_q.push_back(64'h0C0B_0A09_0807_0605);
        send_msg(64'h0C0B_0A09_0807_0605, 3);
        check("t2_realign_header", 64'(msg_header), 64'h05);
        idle(2);
        check("t2_drained", 64'(exp_q.size()), 64'd0);

        // Stalled consumer: A held, B dropped with overflow, then A drains.
        msg_ready = 1'b0;
        o0 = overflow_cnt;
        exp_q.push_back(64'hA7A6_A5A4_A3A2_A1A0);
        send_msg(64'hA7A6_A5A4_A3A2_A1A0, 1);
        send_msg(64'hB7B6_B5B4_B3B2_B1B0, 1);
        idle(1);
        check("t3_valid_held", 64'(msg_valid), 64'd1);
        check("t3_header_kept", 64'(msg_header), 64'hA0);
        check("t3_payload_kept", 64'(msg_payload), 64'h00A7_A6A5_A4A3_A2A1);
        check("t3_overflow_count", 64'(overflow_cnt - o0), 64'd1);
        check("t3_not_consumed", 64'(exp_q.size()), 64'd1);
        msg_ready = 1'b1;
        idle(1);
        check("t3_valid_cleared", 64'(msg_valid), 64'd0);
        check("t3_drained", 64'(exp_q.size()), 64'd0);

        // Ready rises in the cycle the second message completes: no bubble.
        msg_ready = 1'b0;
        o0 = overflow_cnt;
        exp_q.push_back(64'hC7C6_C5C4_C3C2_C1C0);
        exp_q.push_back(64'hD7D6_D5D4_D3D2_D1D0);
        send_msg(64'hC7C6_C5C4_C3C2_C1C0, 1);
        msg_d = 64'hD7D6_D5D4_D3D2_D1D0;
        for (int i = 0; i < 7; i++) begin
            drive_byte(msg_d[i*8 +: 8]);
            idle(1);
        end
        drive_byte(msg_d[63:56]);
        msg_ready = 1'b1;
        idle(1);
        check("t4_no_bubble", 64'(msg_valid), 64'd1);
        check("t4_new_header", 64'(msg_header), 64'hD0);
        idle(2);
        check("t4_no_overflow", 64'(overflow_cnt - o0), 64'd0);
        check("t4_drained", 64'(exp_q.size()), 64'd0);
        check("t4_valid_cleared", 64'(msg_valid), 64'd0);

        // Reset mid-message: outputs zero, partial message silently discarded.
        t0 = timeout_cnt;
        for (int i = 0; i < 5; i++) begin
            drive_byte(8'(8'h50 + i));
            idle(2);
        end
        n_reset = 1'b0;
        idle(2);
        check("t5_rst_outputs", 64'({msg_valid, timeout_err, overflow_err}), 64'd0);
        check("t5_rst_header", 64'(msg_header), 64'd0);
        check("t5_rst_payload", 64'(msg_payload), 64'd0);
        n_reset = 1'b1;
        idle(TO + 5);
        check("t5_no_timeout", 64'(timeout_cnt - t0), 64'd0);
        exp_q.push_back(64'h2726_2524_2322_2120);
        send_msg(64'h2726_2524_2322_2120, 4);
        check("t5_msg_valid", 64'(msg_valid), 64'd1);
        idle(2);
        check("t5_drained", 64'(exp_q.size()), 64'd0);

        // Back-to-back strobes on consecutive cycles.
        v0 = valid_cycles;
        exp_q.push_back(64'h1716_1514_1312_1110);
        send_msg(64'h1716_1514_1312_1110, 0);
        check("t6_valid", 64'(msg_valid), 64'd1);
        check("t6_header", 64'(msg_header), 64'h10);
        check("t6_payload", 64'(msg_payload), 64'h0017_1615_1413_1211);
        idle(2);
        check("t6_valid_cycles", 64'(valid_cycles - v0), 64'd1);
        check("t6_drained", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
